key_state_tracker: RTL and testbench
====================================

# key_state_tracker

Converts the byte stream from the PS/2 receiver (scan code set 2) into held-key levels for the player controller. Decodes E0 (extended) and F0 (break) prefixes, tracks ten physical keys, and ORs aliases into the 5-bit `keydown` vector: arrows plus WASD, space for jump. Also emits a one-cycle `start` pulse on Enter make. Sits between the PS/2 byte receiver and the Mario movement FSM.

## Interface
- `TIMEOUT_CYCLES`, default 2_000_000: idle cycles after which a pending prefix is discarded (about 20 ms at 100 MHz).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `data` in 8: received scan-code byte; valid only when `valid`=1.
- `valid` in 1: one-cycle strobe per received byte; no backpressure.
- `keydown` out 5: held levels; [0] up, [1] left, [2] right, [3] down, [4] jump.
- `start` out 1: one-cycle pulse on Enter (5A) make.

## Operation
- Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Reset state is IDLE.
- In IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - Any other byte is a plain make code; stay in IDLE.
- In EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT (restarts the prefix).
  - Any other byte is an extended make code; go to IDLE.
- In BRK:
  - F0 stays in BRK.
  - E0 goes to EXT_BRK.
  - Any other byte is a plain break code; go to IDLE.
- In EXT_BRK:
  - E0 or F0 stays in EXT_BRK.
  - Any other byte is an extended break code; go to IDLE.
- Tracked keys and scan codes:

| Key | Code | Type |
|---|---|---|
| Up | E0 75 | extended |
| Left | E0 6B | extended |
| Right | E0 74 | extended |
| Down | E0 72 | extended |
| W | 1D | plain |
| A | 1C | plain |
| D | 23 | plain |
| S | 1B | plain |
| Space | 29 | plain |
| Enter | 5A | plain |

- A make code sets the key's held bit; a break code clears it. Repeated makes (typematic) are idempotent.
- Codes that are unmapped, or mapped but with the wrong plain/extended type, are ignored. The FSM still returns to IDLE. Example: plain 75 (keypad 8) does not affect up.
- Control bytes AA, FA, FE, EE, 00, FF and E1 are ignored in every state, and the FSM returns to IDLE.
- `keydown` is a pure function of the held bits:
  - [0] = Up | W
  - [1] = Left | A
  - [2] = Right | D
  - [3] = Down | S
  - [4] = Space
- `start` is asserted for exactly one cycle when an Enter make is decoded. It is asserted only if Enter was not already held, so typematic repeat does not retrigger it.
- Timeout:
  - A 21-bit idle counter clears on every `valid`.
  - When the FSM is not in IDLE and the counter reaches `TIMEOUT_CYCLES`-1, the FSM returns to IDLE. Held bits are unchanged.
  - The counter saturates; it never wraps.

## Timing
- Reset values: FSM IDLE, all ten held bits 0, `keydown`=5'b00000, `start`=0, counter 0.
- Latency: a final code byte with `valid` high in cycle N updates the held bits, `keydown` and `start` at the edge ending cycle N. They are visible in cycle N+1.
- Prefix bytes alone never change outputs.
- Back-to-back `valid` on consecutive cycles is fully supported, one byte per cycle.
- `rst` asserted while `valid`=1 takes priority: the byte is discarded.
- A reset mid-sequence, for example after E0, returns the FSM to IDLE. The following byte is decoded as plain.
- A timeout and a `valid` in the same cycle: `valid` wins, and the byte is decoded in the current state.
- Alias overlap: pressing A and Left, then releasing Left, keeps `keydown[1]`=1 until A is also released.

## Structure
- Shared package `key_pkg` holds:
  - scan-code constants: E0, F0, the ten key codes, and the control bytes;
  - held-bit index constants: KEY_UP … KEY_ENTER;
  - `keydown` bit indices: KD_UP=0, KD_LEFT=1, KD_RIGHT=2, KD_DOWN=3, KD_JUMP=4. The movement FSM shares these.
- One natural sub-module, `scan_code_map`: combinational. It takes (byte, extended flag) and produces a one-hot 10-bit key select plus a hit flag. The top level holds the FSM, held register, timeout counter and output logic.

## Test plan
- E0 75, then E0 F0 75 -> `keydown`=00001 from the cycle after 75 until the cycle after the final 75, then 00000.
- 1C, then E0 6B, then E0 F0 6B -> `keydown[1]` stays 1 throughout. Then F0 1C -> `keydown[1]`=0.
- 5A 5A 5A (typematic), then F0 5A, then 5A -> `start` pulses exactly twice: after the first 5A and after the last 5A.
- Plain 75, E1, AA -> `keydown` stays 00000. The next byte 29 sets `keydown`=10000.
- E0, then `TIMEOUT_CYCLES` idle cycles, then 6B -> treated as plain; `keydown` unchanged. Repeat with a gap of `TIMEOUT_CYCLES`-2 -> `keydown[1]`=1.
- With 29 held, assert `rst` coincident with `valid` and `data`=F0 -> `keydown`=00000 next cycle. The next 29 is a make, so `keydown[4]`=1.

Source files
------------

// File: rtl/key_state_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared scan-code constants, held-key and keydown bit indices,
//               decoder state encoding for the PS/2 key state tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  // Number of physical keys tracked
  localparam int N_KEYS = 10;
  localparam int CNT_W  = 21;

  // Prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Tracked key codes (extended: up/left/right/down)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Keyboard control / status bytes that never carry key information
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  // Held-bit indices
  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_W     = 4;
  localparam int KEY_A     = 5;
  localparam int KEY_D     = 6;
  localparam int KEY_S     = 7;
  localparam int KEY_SPACE = 8;
  localparam int KEY_ENTER = 9;

  // keydown bit indices, shared with the movement FSM
  localparam int KD_UP    = 0;
  localparam int KD_LEFT  = 1;
  localparam int KD_RIGHT = 2;
  localparam int KD_DOWN  = 3;
  localparam int KD_JUMP  = 4;

  typedef logic [N_KEYS-1:0] key_vec_t;

  // Decoder state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_EXT     = 2'd1;
  localparam state_t ST_BRK     = 2'd2;
  localparam state_t ST_EXT_BRK = 2'd3;

  // True for bytes that abort any prefix and are otherwise ignored
  function automatic logic is_ctrl(input logic [7:0] b);
    logic r;
    case (b)
      SC_BAT_OK, SC_ACK, SC_RESEND, SC_ECHO,
      SC_ERR_LO, SC_ERR_HI, SC_PAUSE: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_state_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : key_state_tracker_if
// Description : Byte stream in from the PS/2 receiver, key levels and start
//               pulse out to the player controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_state_tracker_if;
  logic [7:0] data;
  logic       valid;
  logic [4:0] keydown;
  logic       start;

  // Byte source side (PS/2 receiver / testbench)
  modport master (output data, output valid, input keydown, input start);
  // Tracker side
  modport slave  (input data, input valid, output keydown, output start);
endinterface
`default_nettype wire

// File: rtl/key_state_tracker_scan_code_map.sv
`default_nettype none
// ============================================================================
// Module      : scan_code_map
// Description : Maps a final scan-code byte plus extended flag onto a one-hot
//               key select. Wrong plain/extended type yields no hit.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_code_map
  import key_pkg::*;
(
  input  wire logic [7:0] i_code,
  input  wire logic       i_ext,
  output key_vec_t        o_sel,
  output logic            o_hit
);

  // Table lookup split by code type so a plain 75 never aliases Up
  always_comb begin
    o_sel = '0;
    if (i_ext) begin
      case (i_code)
        SC_UP:    o_sel[KEY_UP]    = 1'b1;
        SC_LEFT:  o_sel[KEY_LEFT]  = 1'b1;
        SC_RIGHT: o_sel[KEY_RIGHT] = 1'b1;
        SC_DOWN:  o_sel[KEY_DOWN]  = 1'b1;
        default:  o_sel = '0;
      endcase
    end else begin
      case (i_code)
        SC_W:     o_sel[KEY_W]     = 1'b1;
        SC_A:     o_sel[KEY_A]     = 1'b1;
        SC_D:     o_sel[KEY_D]     = 1'b1;
        SC_S:     o_sel[KEY_S]     = 1'b1;
        SC_SPACE: o_sel[KEY_SPACE] = 1'b1;
        SC_ENTER: o_sel[KEY_ENTER] = 1'b1;
        default:  o_sel = '0;
      endcase
    end
    o_hit = |o_sel;
  end

endmodule
`default_nettype wire

// File: rtl/key_state_tracker.sv
`default_nettype none
// ============================================================================
// Module      : key_state_tracker
// Description : Decodes PS/2 set-2 E0/F0 prefixes, tracks ten held keys and
//               drives aliased keydown levels plus an Enter start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_state_tracker
  import key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input wire logic           clk,
  input wire logic           rst,
  key_state_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  key_vec_t         r_held;
  key_vec_t         w_held_nxt;
  logic             r_start;
  logic             w_start_nxt;
  logic [CNT_W-1:0] r_idle_cnt;

  logic     w_is_ctrl;
  logic     w_is_e0;
  logic     w_is_f0;
  logic     w_final;
  logic     w_ext;
  logic     w_brk;
  logic     w_timeout;
  key_vec_t w_sel;
  logic     w_hit;

  assign w_is_ctrl = is_ctrl(bus.data);
  assign w_is_e0   = (bus.data == SC_E0);
  assign w_is_f0   = (bus.data == SC_F0);
  assign w_final   = bus.valid & ~w_is_ctrl & ~w_is_e0 & ~w_is_f0;
  assign w_ext     = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_brk     = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  assign w_timeout = (r_idle_cnt >= c_timeout_last);

  scan_code_map u_map (
    .i_code (bus.data),
    .i_ext  (w_ext),
    .o_sel  (w_sel),
    .o_hit  (w_hit)
  );

  // Decoder state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Prefix tracking; a byte in the timeout cycle is decoded before the timeout
  always_comb begin
    w_state_nxt = r_state;
    if (bus.valid) begin
      if (w_is_ctrl) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:    w_state_nxt = w_is_e0 ? ST_EXT : (w_is_f0 ? ST_BRK : ST_IDLE);
          ST_EXT:     w_state_nxt = w_is_f0 ? ST_EXT_BRK : (w_is_e0 ? ST_EXT : ST_IDLE);
          ST_BRK:     w_state_nxt = w_is_e0 ? ST_EXT_BRK : (w_is_f0 ? ST_BRK : ST_IDLE);
          ST_EXT_BRK: w_state_nxt = (w_is_e0 || w_is_f0) ? ST_EXT_BRK : ST_IDLE;
          default:    w_state_nxt = ST_IDLE;
        endcase
      end
    end else if ((r_state != ST_IDLE) && w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Make sets / break clears the selected key; Enter make starts once per press
  always_comb begin
    w_held_nxt  = r_held;
    w_start_nxt = 1'b0;
    if (w_final && w_hit) begin
      if (w_brk) begin
        w_held_nxt = r_held & ~w_sel;
      end else begin
        w_held_nxt  = r_held | w_sel;
        w_start_nxt = w_sel[KEY_ENTER] & ~r_held[KEY_ENTER];
      end
    end
  end

  // Held keys and start pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held  <= '0;
      r_start <= 1'b0;
    end else begin
      r_held  <= w_held_nxt;
      r_start <= w_start_nxt;
    end
  end

  // Saturating idle counter, cleared by every received byte
  always_ff @(posedge clk) begin
    if (rst || bus.valid)     r_idle_cnt <= '0;
    else if (~&r_idle_cnt)    r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign bus.keydown[KD_UP]    = r_held[KEY_UP]    | r_held[KEY_W];
  assign bus.keydown[KD_LEFT]  = r_held[KEY_LEFT]  | r_held[KEY_A];
  assign bus.keydown[KD_RIGHT] = r_held[KEY_RIGHT] | r_held[KEY_D];
  assign bus.keydown[KD_DOWN]  = r_held[KEY_DOWN]  | r_held[KEY_S];
  assign bus.keydown[KD_JUMP]  = r_held[KEY_SPACE];
  assign bus.start             = r_start;

endmodule
`default_nettype wire

// File: tb/tb_key_state_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_state_tracker
// Description : Randomized + directed scoreboard bench for key_state_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_state_tracker;

  localparam int T = 16;

  // Key table in the bench's own order: up,left,right,down,W,A,D,S,space,enter
  localparam logic [7:0] KCODE [10] = '{8'h75, 8'h6B, 8'h74, 8'h72, 8'h1D,
                                        8'h1C, 8'h23, 8'h1B, 8'h29, 8'h5A};
  localparam bit         KEXT  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] CTRL  [7]  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE,
                                        8'h00, 8'hFF, 8'hE1};

  logic clk = 1'b0;
  logic rst;

  key_state_tracker_if bus ();

  key_state_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] kd;
    logic       st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: pending prefix flags, key levels, idle cycles since last byte
  bit       m_ext;
  bit       m_brk;
  bit [9:0] m_held;
  int       m_idle;

  function automatic int lookup(input bit ext, input logic [7:0] b);
    for (int i = 0; i < 10; i++)
      if (KCODE[i] == b && KEXT[i] == ext) return i;
    return -1;
  endfunction

  function automatic bit is_ctrl_b(input logic [7:0] b);
    for (int i = 0; i < 7; i++)
      if (CTRL[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of input and queue the response expected after its edge
  task automatic tick(input bit r, input bit v, input logic [7:0] d);
    exp_t e;
    int   k;
    @(negedge clk);
    rst       = r;
    bus.valid = v;
    bus.data  = d;
    e.st = 1'b0;
    if (r) begin
      m_ext = 0; m_brk = 0; m_held = '0; m_idle = 0;
    end else if (v) begin
      if ((m_ext || m_brk) && m_idle >= T) begin
        m_ext = 0; m_brk = 0;
      end
      if (is_ctrl_b(d)) begin
        m_ext = 0; m_brk = 0;
      end else if (d == 8'hE0) begin
        m_ext = 1;
      end else if (d == 8'hF0) begin
        m_brk = 1;
      end else begin
        k = lookup(m_ext, d);
        if (k >= 0) begin
          if (m_brk) m_held[k] = 1'b0;
          else begin
            if (k == 9 && !m_held[9]) e.st = 1'b1;
            m_held[k] = 1'b1;
          end
        end
        m_ext = 0; m_brk = 0;
      end
      m_idle = 0;
    end else begin
      m_idle++;
    end
    e.kd = {m_held[8], m_held[3] | m_held[7], m_held[2] | m_held[6],
            m_held[1] | m_held[5], m_held[0] | m_held[4]};
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: compare DUT outputs just after each edge against queued expectations
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (bus.keydown !== mon_e.kd) begin
        errors++;
        $display("FAIL keydown t=%0t got=%b exp=%b", $time, bus.keydown, mon_e.kd);
      end
      checks++;
      if (bus.start !== mon_e.st) begin
        errors++;
        $display("FAIL start t=%0t got=%b exp=%b", $time, bus.start, mon_e.st);
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         sel;
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    m_ext = 0; m_brk = 0; m_held = '0; m_idle = 0;

    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    idle(2);

    // Extended Up make / break
    send(8'hE0); send(8'h75); idle(2);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);

    // Alias overlap A + Left
    send(8'h1C); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
    send(8'hF0); send(8'h1C); idle(1);

    // Enter typematic and re-press
    send(8'h5A); send(8'h5A); send(8'h5A);
    send(8'hF0); send(8'h5A); send(8'h5A); idle(1);
    send(8'hF0); send(8'h5A);

    // Wrong type / control bytes, then Space
    send(8'h75); send(8'hE1); send(8'hAA); send(8'h29); idle(1);
    send(8'hF0); send(8'h29);
    send(8'hE0); send(8'hFA); send(8'h6B);

    // Timeout boundaries around a pending E0
    send(8'hE0); idle(T);     send(8'h6B); idle(1);
    send(8'hE0); idle(T - 2); send(8'h6B); idle(1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); idle(T - 1); send(8'h6B); idle(1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'h29); send(8'hF0); idle(T); send(8'h29); idle(1);

    // Reset coincident with a byte, and reset mid-sequence
    tick(1'b1, 1'b1, 8'hF0);
    send(8'h29); idle(1);
    send(8'hE0); tick(1'b1, 1'b0, 8'h00); send(8'h75); idle(1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 11));
      case (sel)
        0, 1, 2, 3: b = KCODE[$urandom_range(0, 9)];
        4, 5:       b = 8'hE0;
        6, 7:       b = 8'hF0;
        8:          b = CTRL[$urandom_range(0, 6)];
        9:          b = 8'(($urandom & 32'hFF));
        default:    b = 8'h5A;
      endcase
      if ($urandom_range(0, 199) == 0)      tick(1'b1, $urandom_range(0, 1) == 1, b);
      else if ($urandom_range(0, 99) < 3)   idle(int'($urandom_range(T - 2, T + 1)));
      else if ($urandom_range(0, 4) == 0)   idle(1);
      else                                  send(b);
    end
    idle(2);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
